// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// sequencer states and small decode helpers.
package mdu_pkg;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  // LO fill for a zero divisor; sliced to WIDTH, so WIDTH may not exceed 64.
  localparam int              DBZ_MAX_W = 64;
  localparam logic [DBZ_MAX_W-1:0] DBZ_LO = '1;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes on the way in, and
// result negation / divide-by-zero substitution on the way out.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg_a,
  output logic             neg_b,
  input  logic [2:0]       run_op,
  input  logic             run_neg_a,
  input  logic             run_neg_b,
  input  logic             div_zero,
  input  logic [WIDTH-1:0] a_raw,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    neg_a = is_signed_op(req_op) & a[WIDTH-1];
    neg_b = is_signed_op(req_op) & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
  end

  // Remainder follows the dividend's sign; quotient and product follow the XOR.
  always_comb begin
    prod     = {raw_hi, raw_lo};
    prod_neg = -prod;
    fix_hi   = raw_hi;
    fix_lo   = raw_lo;
    case (run_op)
      OP_MULT: begin
        if (run_neg_a ^ run_neg_b) begin
          fix_hi = prod_neg[2*WIDTH-1:WIDTH];
          fix_lo = prod_neg[WIDTH-1:0];
        end
      end
      OP_DIVU, OP_DIV: begin
        if (div_zero) begin
          fix_hi = a_raw;
          fix_lo = DBZ_LO[WIDTH-1:0];
        end else begin
          if (run_neg_a ^ run_neg_b) fix_lo = -raw_lo;
          if (run_neg_a)             fix_hi = -raw_hi;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle in RUN,
// sign correction and write-back in FIX.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             neg_a_q, neg_b_q, b_zero_q;
  logic [WIDTH-1:0] a_q, opnd_q, acc_hi, acc_lo;

  logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
  logic             neg_a, neg_b;
  logic             accept, do_mthi, do_mtlo, step, finish;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .req_op    (op),
    .a         (a),
    .b         (b),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .run_op    (op_q),
    .run_neg_a (neg_a_q),
    .run_neg_b (neg_b_q),
    .div_zero  (b_zero_q),
    .a_raw     (a_q),
    .raw_hi    (acc_hi),
    .raw_lo    (acc_lo),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !op[2])         state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_W'(1))        state_nxt = S_FIX;
      S_FIX:                                state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == S_IDLE) && start && !op[2];
    do_mthi = (state == S_IDLE) && start && (op == OP_MTHI);
    do_mtlo = (state == S_IDLE) && start && (op == OP_MTLO);
    step    = (state == S_RUN);
    finish  = (state == S_FIX);
    busy    = (state != S_IDLE);
  end

  // Shared accumulator: {product hi, lo} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_q : '0)};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      op_q     <= OP_MULTU;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else if (accept) begin
      cnt      <= CNT_W'(WIDTH);
      op_q     <= op;
      neg_a_q  <= neg_a;
      neg_b_q  <= neg_b;
      b_zero_q <= (b == '0);
      a_q      <= a;
      opnd_q   <= op[1] ? mag_b : mag_a;
      acc_hi   <= '0;
      acc_lo   <= op[1] ? mag_a : mag_b;
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (!op_q[1]) begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (!div_trial[WIDTH]) begin
        acc_hi <= div_trial[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi <= div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      HI          <= '0;
      LO          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= finish;
      div_by_zero <= finish && op_q[1] && b_zero_q;
      if (finish) begin
        HI <= fix_hi;
        LO <= fix_lo;
      end else if (do_mthi) begin
        HI <= a;
      end else if (do_mtlo) begin
        LO <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus random traffic,
// all checked every cycle against a latency/arithmetic reference model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  int          m_cnt = 0;

  mdu_hilo #(.WIDTH(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 CLK = ~CLK;

  // Reference arithmetic straight from the ISA rules, using wide integers.
  function automatic void model_compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                        output logic [31:0] hi, output logic [31:0] lo, output bit z);
    logic [63:0] p;
    longint      sx, sy, q, r;
    z  = 1'b0;
    hi = '0;
    lo = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; hi = p[63:32]; lo = p[31:0]; end
      OP_MULT:  begin p = 64'(sx * sy);            hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          z = 1'b1; hi = x; lo = 32'hFFFF_FFFF;
        end else if (o == OP_DIVU) begin
          lo = x / y; hi = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endfunction

  // Cycle model: result appears WIDTH+1 edges after acceptance.
  always @(posedge CLK) begin : model
    logic [31:0] ph, pl;
    bit          pz;
    if (RST) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz; m_done <= 1'b1; m_busy <= 1'b0;
        end
      end else if (start) begin
        if (op <= OP_DIV) begin
          model_compute(op, a, b, ph, pl, pz);
          p_hi <= ph; p_lo <= pl; p_dbz <= pz;
          m_busy <= 1'b1;
          m_cnt  <= 33;
        end else if (op == OP_MTHI) begin
          m_hi <= a;
        end else if (op == OP_MTLO) begin
          m_lo <= a;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      checkOutput("busy", 64'(busy), 64'(m_busy));
      checkOutput("done", 64'(done), 64'(m_done));
      checkOutput("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      checkOutput("HI", 64'(HI), 64'(m_hi));
      checkOutput("LO", 64'(LO), 64'(m_lo));
    end
  end

  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge CLK);
    start = s;
    op    = o;
    a     = x;
    b     = y;
  endtask

  task automatic wait_done(input bit keep_start, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (!keep_start) start = 1'b0;
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL done_timeout: no done within 40 cycles at %0t", $time);
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int lat, bc;
    applyStimulus(1'b1, o, x, y);
    wait_done(1'b0, lat, bc);
    checkOutput({name, "_latency"}, 64'(lat), 64'd33);
    checkOutput({name, "_hi"}, 64'(HI), 64'(ehi));
    checkOutput({name, "_lo"}, 64'(LO), 64'(elo));
    checkOutput({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ph, pl;
    bit          pz;
    int          lat, bc, seen;

    model_compute(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ph, pl, pz);
    checkOutput("pin_multu", {ph, pl}, 64'hFFFF_FFFE_0000_0001);
    model_compute(OP_MULT, 32'hFFFF_FFFD, 32'h5, ph, pl, pz);
    checkOutput("pin_mult", {ph, pl}, 64'hFFFF_FFFF_FFFF_FFF1);
    model_compute(OP_DIV, 32'hFFFF_FFF9, 32'h2, ph, pl, pz);
    checkOutput("pin_div", {ph, pl}, 64'hFFFF_FFFF_FFFF_FFFD);
    model_compute(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ph, pl, pz);
    checkOutput("pin_div_ovf", {ph, pl}, 64'h0000_0000_8000_0000);
    model_compute(OP_DIVU, 32'h5, 32'h0, ph, pl, pz);
    checkOutput("pin_dbz", {ph, pl, 31'd0, pz}, {64'h0000_0005_FFFF_FFFF, 32'd1});

    repeat (2) @(negedge CLK);
    RST = 1'b0;
    checkOutput("reset_hi", 64'(HI), 64'd0);
    checkOutput("reset_lo", 64'(LO), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    chk_en = 1'b1;

    applyStimulus(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, lat, bc);
    checkOutput("multu_latency", 64'(lat), 64'd33);
    checkOutput("multu_busy_cycles", 64'(bc), 64'd33);
    checkOutput("multu_hi", 64'(HI), 64'hFFFF_FFFE);
    checkOutput("multu_lo", 64'(LO), 64'h0000_0001);

    run_check("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_check("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_check("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_check("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_check("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    @(negedge CLK);
    checkOutput("dbz_one_cycle", 64'(div_by_zero), 64'd0);

    applyStimulus(1'b1, OP_MULTU, 32'd3, 32'd4);
    applyStimulus(1'b1, OP_DIVU, 32'd9, 32'd2);
    applyStimulus(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    wait_done(1'b0, lat, bc);
    checkOutput("busy_ignore_hi", 64'(HI), 64'd0);
    checkOutput("busy_ignore_lo", 64'(LO), 64'hC);

    applyStimulus(1'b1, OP_MULTU, 32'd3, 32'd4);
    repeat (9) begin
      @(negedge CLK);
      start = 1'b0;
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_hi", 64'(HI), 64'd0);
    checkOutput("midreset_lo", 64'(LO), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done === 1'b1) seen++;
    end
    checkOutput("midreset_no_done", 64'(seen), 64'd0);

    applyStimulus(1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
    applyStimulus(1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    checkOutput("mthi_hi", 64'(HI), 64'h1234_5678);
    @(negedge CLK);
    start = 1'b0;
    checkOutput("mtlo_lo", 64'(LO), 64'h9ABC_DEF0);
    checkOutput("move_no_done", 64'(done), 64'd0);

    applyStimulus(1'b1, OP_MULTU, 32'd2, 32'd3);
    wait_done(1'b1, lat, bc);
    checkOutput("b2b_first_latency", 64'(lat), 64'd33);
    checkOutput("b2b_first_lo", 64'(LO), 64'd6);
    wait_done(1'b0, lat, bc);
    checkOutput("b2b_second_latency", 64'(lat), 64'd33);
    checkOutput("b2b_second_lo", 64'(LO), 64'd6);

    repeat (3000) begin
      @(negedge CLK);
      RST   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = rand_operand();
      b     = rand_operand();
    end
    @(negedge CLK);
    RST   = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge CLK);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
